// File: rtl/obi_pkg.sv
// Shared OBI request/response payload types.
//   obi_req_t  : req, we, be, addr, wdata (initiator -> target)
//   obi_resp_t : gnt, rvalid, rdata       (target -> initiator)
package obi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef struct packed {
    logic              req;
    logic              we;
    logic [BE_W-1:0]   be;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;
  } obi_resp_t;

endpackage

// File: rtl/obi_xbar_pkg.sv
// Helpers for the banked OBI crossbar: error read data, bank decode and
// bank-local address remap for contiguous or word-interleaved layouts,
// and an index-width helper that never returns zero.
package obi_xbar_pkg;

  localparam logic [31:0] ERR_RDATA = 32'hBADCAB1E;

  // Width of an index into n items; at least 1 bit so n == 1 still elaborates.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bank selected by a region offset.
  function automatic logic [31:0] bank_index(input logic [31:0] off,
                                             input int unsigned wb,
                                             input int unsigned nb,
                                             input bit          interleaved);
    if (interleaved) return (off >> 2) & ((32'd1 << nb) - 32'd1);
    return off >> wb;
  endfunction

  // Byte address inside the selected bank, truncated to wb bits.
  function automatic logic [31:0] bank_remap(input logic [31:0] off,
                                             input int unsigned wb,
                                             input int unsigned nb,
                                             input bit          interleaved);
    logic [31:0] a;
    if (interleaved) a = ((off >> (2 + nb)) << 2) | (off & 32'd3);
    else             a = off;
    return a & ((32'd1 << wb) - 32'd1);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered priority pointer.
//   clk_i, rst_i : clock, synchronous active-high reset
//   i_req        : request vector
//   i_advance    : winner was accepted; move pointer past it
//   o_gnt_oh     : one-hot winner (all zero when nobody requests)
//   o_gnt_idx    : winner index (0 when nobody requests)
module rr_arbiter
  import obi_xbar_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned IW      = idx_width(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic [NUM_REQ-1:0] o_gnt_oh,
  output logic [IW-1:0]      o_gnt_idx
);

  logic [IW-1:0] r_ptr;
  logic          w_found;

  // (base + k) mod NUM_REQ for base < NUM_REQ, k <= NUM_REQ.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                             input int unsigned   k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // First requester at or after the pointer, wrapping.
  always_comb begin
    o_gnt_idx = '0;
    w_found   = 1'b0;
    o_gnt_oh  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (!w_found && i_req[wrap_add(r_ptr, k)]) begin
        w_found   = 1'b1;
        o_gnt_idx = wrap_add(r_ptr, k);
      end
    end
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      o_gnt_oh[k] = w_found && (o_gnt_idx == IW'(k));
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)          r_ptr <= '0;
    else if (i_advance) r_ptr <= wrap_add(o_gnt_idx, 1);
  end

endmodule

// File: rtl/obi_bank_xbar.sv
// Multi-master OBI crossbar in front of a banked SRAM. Each master request
// is decoded to a bank, each bank arbitrates round-robin, and the bank's
// fixed 1-cycle read response is routed back to the issuing master.
// Out-of-range accesses are granted at once and answered with ERR_RDATA.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   master_req_i  : per-master OBI requests
//   master_resp_o : per-master gnt (combinational), rvalid/rdata (next cycle)
//   bank_req_o    : per-bank OBI requests (combinational)
//   bank_resp_i   : per-bank gnt, rvalid, rdata
module obi_bank_xbar
  import obi_pkg::*;
  import obi_xbar_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned NUM_BANKS   = 2,
  parameter int unsigned BANK_SIZE_B = 32768,
  parameter bit          INTERLEAVED = 1'b0,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  obi_req_t  master_req_i  [NUM_MASTERS],
  output obi_resp_t master_resp_o [NUM_MASTERS],
  output obi_req_t  bank_req_o    [NUM_BANKS],
  input  obi_resp_t bank_resp_i   [NUM_BANKS]
);

  localparam int unsigned WB   = $clog2(BANK_SIZE_B);
  localparam int unsigned NB   = $clog2(NUM_BANKS);
  localparam int unsigned MIW  = idx_width(NUM_MASTERS);
  localparam logic [63:0] SPAN = 64'(NUM_BANKS) * 64'(BANK_SIZE_B);

  if (INTERLEAVED && ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_il_chk
    $error("obi_bank_xbar: INTERLEAVED needs a power-of-2 NUM_BANKS");
  end
  if ((BANK_SIZE_B & (BANK_SIZE_B - 1)) != 0) begin : g_size_chk
    $error("obi_bank_xbar: BANK_SIZE_B must be a power of 2");
  end

  logic [31:0]            w_off   [NUM_MASTERS];
  logic [31:0]            w_bank  [NUM_MASTERS];
  logic [31:0]            w_baddr [NUM_MASTERS];
  logic [NUM_BANKS-1:0]   w_tgt   [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] w_oor;
  logic [NUM_MASTERS-1:0] w_breq  [NUM_BANKS];
  logic [NUM_MASTERS-1:0] w_win_oh[NUM_BANKS];
  logic [MIW-1:0]         w_win   [NUM_BANKS];
  logic [NUM_BANKS-1:0]   w_hs;

  logic [NUM_BANKS-1:0]   r_rsp_vld;
  logic [NUM_BANKS-1:0]   r_rsp_we;
  logic [MIW-1:0]         r_rsp_mst [NUM_BANKS];
  logic [NUM_MASTERS-1:0] r_err_vld;

  // Address decode and per-bank request vectors.
  always_comb begin
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      w_off[m]   = master_req_i[m].addr - BASE_ADDR;
      w_bank[m]  = bank_index(w_off[m], WB, NB, INTERLEAVED);
      w_baddr[m] = bank_remap(w_off[m], WB, NB, INTERLEAVED);
      // Offsets below BASE_ADDR wrap to large values and land here too.
      w_oor[m]   = (w_bank[m] >= 32'(NUM_BANKS)) || ({32'd0, w_off[m]} >= SPAN);
      w_tgt[m]   = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (master_req_i[m].req && !w_oor[m] && (w_bank[m] == 32'(b)))
          w_tgt[m][b] = 1'b1;
      end
    end
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        w_breq[b][m] = w_tgt[m][b];
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_arb
    rr_arbiter #(
      .NUM_REQ (NUM_MASTERS),
      .IW      (MIW)
    ) u_arb (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .i_req     (w_breq[b]),
      .i_advance (w_hs[b]),
      .o_gnt_oh  (w_win_oh[b]),
      .o_gnt_idx (w_win[b])
    );
  end

  // Bank request muxing, master grants and response routing.
  always_comb begin
    w_hs = '0;
    for (int unsigned b = 0; b < NUM_BANKS; b++) begin
      bank_req_o[b]     = '0;
      bank_req_o[b].req = |w_breq[b];
      if (|w_breq[b]) begin
        bank_req_o[b].we    = master_req_i[w_win[b]].we;
        bank_req_o[b].be    = master_req_i[w_win[b]].be;
        bank_req_o[b].wdata = master_req_i[w_win[b]].wdata;
        bank_req_o[b].addr  = w_baddr[w_win[b]];
      end
      w_hs[b] = (|w_breq[b]) && bank_resp_i[b].gnt;
    end
    for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
      master_resp_o[m]     = '0;
      master_resp_o[m].gnt = master_req_i[m].req && w_oor[m];
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        if (w_win_oh[b][m] && bank_resp_i[b].gnt) master_resp_o[m].gnt = 1'b1;
      end
      // Responses are suppressed while reset is held so nothing in flight leaks out.
      if (!rst_i) begin
        if (r_err_vld[m]) begin
          master_resp_o[m].rvalid = 1'b1;
          master_resp_o[m].rdata  = ERR_RDATA;
        end
        for (int unsigned b = 0; b < NUM_BANKS; b++) begin
          if (r_rsp_vld[b] && (r_rsp_mst[b] == MIW'(m))) begin
            master_resp_o[m].rvalid = 1'b1;
            master_resp_o[m].rdata  = r_rsp_we[b] ? 32'd0 : bank_resp_i[b].rdata;
          end
        end
      end
    end
  end

  // Remember who owns next cycle's response on each bank.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rsp_vld <= '0;
      r_rsp_we  <= '0;
      r_err_vld <= '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) r_rsp_mst[b] <= '0;
    end else begin
      r_rsp_vld <= w_hs;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        r_rsp_we[b]  <= bank_req_o[b].we;
        r_rsp_mst[b] <= w_win[b];
      end
      for (int unsigned m = 0; m < NUM_MASTERS; m++) begin
        r_err_vld[m] <= master_req_i[m].req && w_oor[m];
      end
    end
  end

  // Banks must answer exactly one cycle after every accepted request.
  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
        assert (bank_resp_i[b].rvalid == r_rsp_vld[b])
          else $error("obi_bank_xbar: bank %0d rvalid out of step with grant", b);
      end
    end
  end

endmodule
